// File: rtl/ctrl_pkg.sv
// Shared encodings for the multicycle controller: states, opcode/funct values,
// mux select codes, ALU ops and the registered control word. ADDM_EN adds the addm states.
package ctrl_pkg;

  typedef enum logic [4:0] {
    S_RESET     = 5'd0,
    S_FETCH     = 5'd1,
    S_FETCH_WAIT= 5'd2,
    S_IR_LOAD   = 5'd3,
    S_DECODE    = 5'd4,
    S_R_EXEC    = 5'd5,
    S_R_WB      = 5'd6,
    S_I_EXEC    = 5'd7,
    S_I_WB      = 5'd8,
    S_ADDR      = 5'd9,
    S_MEM_RD    = 5'd10,
    S_MEM_WAIT  = 5'd11,
    S_MEM_MDR   = 5'd12,
    S_LW_WB     = 5'd13,
    S_MEM_WR    = 5'd14,
    S_BEQ       = 5'd15,
    S_JUMP      = 5'd16,
    S_ADDM_RD   = 5'd17,
    S_ADDM_WAIT = 5'd18,
    S_ADDM_MDR  = 5'd19,
    S_ADDM_EXEC = 5'd20,
    S_ADDM_WB   = 5'd21,
    S_TRAP      = 5'd22
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_ADDM  = 6'h05;

  localparam logic [1:0] SRCA_ALUOUT = 2'b00;
  localparam logic [1:0] SRCA_PC     = 2'b01;
  localparam logic [1:0] SRCA_REGA   = 2'b10;
  localparam logic [1:0] SRCA_MDR    = 2'b11;

  localparam logic [1:0] SRCB_REGB   = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMMSH  = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] ADDR_PC     = 2'b00;
  localparam logic [1:0] ADDR_ALUOUT = 2'b01;
  localparam logic [1:0] ADDR_REGA   = 2'b10;

  localparam logic [2:0] ALU_PASS = 3'b000;
  localparam logic [2:0] ALU_ADD  = 3'b001;
  localparam logic [2:0] ALU_SUB  = 3'b010;
  localparam logic [2:0] ALU_AND  = 3'b011;

  typedef struct packed {
    logic       pcwrite;
    logic [1:0] pcsource;
    logic [1:0] iord;
    logic       memwrite;
    logic       irwrite;
    logic       mdrwrite;
    logic       abwrite;
    logic       aluoutwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic [1:0] srca;
    logic [1:0] srcb;
    logic [2:0] aluop;
    logic       trap;
  } ctrl_t;

  function automatic logic [2:0] rtype_aluop(input logic [5:0] funct);
    case (funct)
      FN_SUB:  return ALU_SUB;
      FN_AND:  return ALU_AND;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/mc_decode.sv
// DECODE-state dispatch: maps opcode/funct to the first execute state.
// With ADDM_EN defined, R-type funct 0x05 dispatches to the addm sequence.
module mc_decode
  import ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output state_t     next
);

  always_comb begin
    next = S_TRAP;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_AND: next = S_R_EXEC;
`ifdef ADDM_EN
          FN_ADDM:                next = S_ADDM_RD;
`endif
          default:                next = S_TRAP;
        endcase
      end
      OP_ADDI:      next = S_I_EXEC;
      OP_LW, OP_SW: next = S_ADDR;
      OP_BEQ:       next = S_BEQ;
      OP_J:         next = S_JUMP;
      default:      next = S_TRAP;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle control FSM; outputs are registered from the next state so they are Moore
// in the current state. ADDM_EN enables the addm (rd <- Mem[rs] + rt) sequence.
module mc_control_unit
  import ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       PCWrite,
  output logic [1:0] PCSource,
  output logic [1:0] IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MDRWrite,
  output logic       ABWrite,
  output logic       ALUOutWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic [1:0] ALUSrcAControl,
  output logic [1:0] ALUSrcBControl,
  output logic [2:0] ALUOp,
  output logic       trap,
  output logic [4:0] state_out
);

  state_t state, nxt, dec_next;
  ctrl_t  ctl, ctl_nxt;
  logic   is_store;

  mc_decode u_decode (
    .opcode (opcode),
    .funct  (funct),
    .next   (dec_next)
  );

  always_comb begin
    nxt = S_TRAP;
    case (state)
      S_RESET:      nxt = S_FETCH;
      S_FETCH:      nxt = S_FETCH_WAIT;
      S_FETCH_WAIT: nxt = S_IR_LOAD;
      S_IR_LOAD:    nxt = S_DECODE;
      S_DECODE:     nxt = dec_next;
      S_R_EXEC:     nxt = S_R_WB;
      S_I_EXEC:     nxt = S_I_WB;
      S_ADDR:       nxt = is_store ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:     nxt = S_MEM_WAIT;
      S_MEM_WAIT:   nxt = S_MEM_MDR;
      S_MEM_MDR:    nxt = S_LW_WB;
`ifdef ADDM_EN
      S_ADDM_RD:    nxt = S_ADDM_WAIT;
      S_ADDM_WAIT:  nxt = S_ADDM_MDR;
      S_ADDM_MDR:   nxt = S_ADDM_EXEC;
      S_ADDM_EXEC:  nxt = S_ADDM_WB;
      S_ADDM_WB:    nxt = S_FETCH;
`endif
      S_R_WB, S_I_WB, S_LW_WB, S_MEM_WR, S_BEQ, S_JUMP: nxt = S_FETCH;
      S_TRAP:       nxt = S_TRAP;
      default:      nxt = S_TRAP;
    endcase
  end

  // Control word for the state being entered; R_EXEC's ALUOp uses funct seen in DECODE.
  always_comb begin
    ctl_nxt = '0;
    case (nxt)
      S_FETCH: begin
        ctl_nxt.iord = ADDR_PC;  ctl_nxt.srca = SRCA_PC;  ctl_nxt.srcb = SRCB_FOUR;
        ctl_nxt.aluop = ALU_ADD; ctl_nxt.pcsource = PCSRC_ALU; ctl_nxt.pcwrite = 1'b1;
      end
      S_IR_LOAD: ctl_nxt.irwrite = 1'b1;
      S_DECODE: begin
        ctl_nxt.abwrite = 1'b1;  ctl_nxt.srca = SRCA_PC;  ctl_nxt.srcb = SRCB_IMMSH;
        ctl_nxt.aluop = ALU_ADD; ctl_nxt.aluoutwrite = 1'b1;
      end
      S_R_EXEC: begin
        ctl_nxt.srca = SRCA_REGA; ctl_nxt.srcb = SRCB_REGB;
        ctl_nxt.aluop = rtype_aluop(funct); ctl_nxt.aluoutwrite = 1'b1;
      end
      S_R_WB: begin
        ctl_nxt.regdst = 1'b1; ctl_nxt.regwrite = 1'b1;
      end
      S_I_EXEC, S_ADDR: begin
        ctl_nxt.srca = SRCA_REGA; ctl_nxt.srcb = SRCB_IMM;
        ctl_nxt.aluop = ALU_ADD;  ctl_nxt.aluoutwrite = 1'b1;
      end
      S_I_WB: ctl_nxt.regwrite = 1'b1;
      S_MEM_RD, S_MEM_WAIT: ctl_nxt.iord = ADDR_ALUOUT;
      S_MEM_MDR: begin
        ctl_nxt.iord = ADDR_ALUOUT; ctl_nxt.mdrwrite = 1'b1;
      end
      S_LW_WB: begin
        ctl_nxt.memtoreg = 1'b1; ctl_nxt.regwrite = 1'b1;
      end
      S_MEM_WR: begin
        ctl_nxt.iord = ADDR_ALUOUT; ctl_nxt.memwrite = 1'b1;
      end
      S_BEQ: begin
        ctl_nxt.srca = SRCA_REGA; ctl_nxt.srcb = SRCB_REGB;
        ctl_nxt.aluop = ALU_SUB;  ctl_nxt.pcsource = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctl_nxt.pcsource = PCSRC_JUMP; ctl_nxt.pcwrite = 1'b1;
      end
`ifdef ADDM_EN
      S_ADDM_RD, S_ADDM_WAIT: ctl_nxt.iord = ADDR_REGA;
      S_ADDM_MDR: begin
        ctl_nxt.iord = ADDR_REGA; ctl_nxt.mdrwrite = 1'b1;
      end
      S_ADDM_EXEC: begin
        ctl_nxt.srca = SRCA_MDR; ctl_nxt.srcb = SRCB_REGB;
        ctl_nxt.aluop = ALU_ADD; ctl_nxt.aluoutwrite = 1'b1;
      end
      S_ADDM_WB: begin
        ctl_nxt.regdst = 1'b1; ctl_nxt.regwrite = 1'b1;
      end
`endif
      S_TRAP:  ctl_nxt.trap = 1'b1;
      default: ctl_nxt = '0;
    endcase
  end

  // lw/sw split is latched in DECODE so opcode is not consulted again in ADDR.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_RESET;
      ctl      <= '0;
      is_store <= 1'b0;
    end else begin
      state <= nxt;
      ctl   <= ctl_nxt;
      if (state == S_DECODE) is_store <= (opcode == OP_SW);
    end
  end

  assign PCWrite        = ctl.pcwrite | ((state == S_BEQ) & zero);
  assign PCSource       = ctl.pcsource;
  assign IorD           = ctl.iord;
  assign MemWrite       = ctl.memwrite;
  assign IRWrite        = ctl.irwrite;
  assign MDRWrite       = ctl.mdrwrite;
  assign ABWrite        = ctl.abwrite;
  assign ALUOutWrite    = ctl.aluoutwrite;
  assign RegWrite       = ctl.regwrite;
  assign RegDst         = ctl.regdst;
  assign MemToReg       = ctl.memtoreg;
  assign ALUSrcAControl = ctl.srca;
  assign ALUSrcBControl = ctl.srcb;
  assign ALUOp          = ctl.aluop;
  assign trap           = ctl.trap;
  assign state_out      = state;

endmodule
